// File: rtl/speed_tick_gen.sv
// ============================================================================
// Module   : speed_tick_gen
// Purpose  : Multi-channel movement-tick generator (ch0 Pac-Man, ch1..4 ghosts).
//            Each channel emits a one-cycle tick every o_period cycles; the
//            period is re-sampled from mode/level/dots only at tick boundaries.
// Options  : SPEED_RAMP_EN - when defined, period changes at a tick boundary
//            are limited to RAMP_STEP (DIED target and restarts still jump).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module speed_tick_gen #(
  parameter int N_CH         = 5,
  parameter int PERIOD_W     = 28,
  parameter int PERIOD_SHIFT = 0,
  parameter int RAMP_STEP    = 131072
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic [4*N_CH-1:0]          i_mode,
  input  logic [7:0]                 i_level,
  input  logic [7:0]                 i_dots_eaten,
  input  logic [N_CH-1:0]            i_restart,
  output logic [N_CH-1:0]            o_tick,
  output logic [PERIOD_W*N_CH-1:0]   o_period
);

  localparam logic [3:0] c_mode_idle   = 4'd0;
  localparam logic [3:0] c_mode_chase  = 4'd1;
  localparam logic [3:0] c_mode_scat   = 4'd2;
  localparam logic [3:0] c_mode_fright = 4'd3;
  localparam logic [3:0] c_mode_died   = 4'd4;
  localparam logic [3:0] c_mode_pause  = 4'd5;

`ifdef SPEED_RAMP_EN
  localparam bit c_ramp_en = 1'b1;
`else
  localparam bit c_ramp_en = 1'b0;
`endif

  // Without ramping the step limit is all-ones, so the ramp collapses to a jump.
  localparam logic [PERIOD_W-1:0] c_ramp_step =
      c_ramp_en ? PERIOD_W'(RAMP_STEP) : {PERIOD_W{1'b1}};

  // Apply the simulation shift and keep the period at least 2 cycles.
  function automatic logic [PERIOD_W-1:0] scale_period(input logic [31:0] raw);
    logic [31:0] sh;
    sh = raw >> PERIOD_SHIFT;
    if (sh < 32'd2) sh = 32'd2;
    return PERIOD_W'(sh);
  endfunction

  // Raw table lookup from mode, shared level and dots-eaten band.
  function automatic logic [31:0] table_period(input logic [3:0] mode,
                                               input logic [7:0] level,
                                               input logic [7:0] dots);
    logic [2:0]  band;
    logic [31:0] p;
    if      (dots <= 8'd15)  band = 3'd0;
    else if (dots <= 8'd30)  band = 3'd1;
    else if (dots <= 8'd60)  band = 3'd2;
    else if (dots <= 8'd200) band = 3'd3;
    else if (dots <= 8'd230) band = 3'd4;
    else                     band = 3'd5;
    p = 32'd6250000;
    case (mode)
      c_mode_chase, c_mode_scat: begin
        if (level == 8'd1) begin
          case (band)
            3'd0:    p = 32'd3125000;
            3'd1:    p = 32'd3000000;
            3'd2:    p = 32'd2800000;
            3'd3:    p = 32'd2500000;
            3'd4:    p = 32'd2200000;
            default: p = 32'd2000000;
          endcase
        end else if (level == 8'd2) begin
          case (band)
            3'd0:    p = 32'd3000000;
            3'd1:    p = 32'd2800000;
            3'd2:    p = 32'd2500000;
            3'd3:    p = 32'd2300000;
            default: p = 32'd2000000;
          endcase
        end else begin
          case (band)
            3'd0:    p = 32'd2800000;
            3'd1:    p = 32'd2500000;
            3'd2:    p = 32'd2300000;
            3'd3:    p = 32'd2000000;
            3'd4:    p = 32'd1800000;
            default: p = 32'd1600000;
          endcase
        end
      end
      c_mode_fright: begin
        if      (level == 8'd1) p = 32'd3125000;
        else if (level == 8'd2) p = 32'd2850000;
        else                    p = 32'd2500000;
      end
      c_mode_died: p = 32'd780000;
      c_mode_idle: p = 32'd3125000;
      default:     p = 32'd6250000;
    endcase
    return p;
  endfunction

  localparam logic [PERIOD_W-1:0] c_idle_period = scale_period(32'd3125000);

  genvar c;
  generate
    for (c = 0; c < N_CH; c++) begin : g_ch
      logic [3:0]          w_mode;
      logic [PERIOD_W-1:0] w_target;
      logic [PERIOD_W-1:0] w_ramped;
      logic [PERIOD_W-1:0] w_next_period;
      logic [PERIOD_W-1:0] r_period;
      logic [PERIOD_W-1:0] r_cnt;
      logic                r_tick;

      assign w_mode   = i_mode[4*c +: 4];
      assign w_target = scale_period(table_period(w_mode, i_level, i_dots_eaten));

      // Move toward the target by at most one step; close enough snaps to it.
      always_comb begin
        w_ramped = w_target;
        if (r_period > w_target) begin
          if ((r_period - w_target) > c_ramp_step) w_ramped = r_period - c_ramp_step;
        end else if (w_target > r_period) begin
          if ((w_target - r_period) > c_ramp_step) w_ramped = r_period + c_ramp_step;
        end
      end

      // A death always snaps immediately so the respawn pace is exact.
      assign w_next_period = (c_ramp_en && (w_mode != c_mode_died)) ? w_ramped : w_target;

      // Per-channel counter: restart, hold (disabled/paused), tick, or advance.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_cnt    <= '0;
          r_tick   <= 1'b0;
          r_period <= c_idle_period;
        end else if (i_restart[c]) begin
          r_cnt    <= '0;
          r_tick   <= 1'b0;
          r_period <= w_target;
        end else if (!i_enable || (w_mode == c_mode_pause)) begin
          r_tick   <= 1'b0;
        end else if (r_cnt >= (r_period - PERIOD_W'(1))) begin
          r_cnt    <= '0;
          r_tick   <= 1'b1;
          r_period <= w_next_period;
        end else begin
          r_cnt    <= r_cnt + PERIOD_W'(1);
          r_tick   <= 1'b0;
        end
      end

      assign o_tick[c]                       = r_tick;
      assign o_period[c*PERIOD_W +: PERIOD_W] = r_period;
    end
  endgenerate

endmodule

`default_nettype wire
